// File: rtl/othello_pkg.sv
// Shared types and direction tables for the sequential flip engine.
// Directions run clockwise from north; dir ^ 4 is the reverse direction.
package othello_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StScan,
      StFlip,
      StFin
   } state_e;

   typedef logic [2:0] dir_t;

   localparam dir_t DirLast    = 3'd7;
   localparam dir_t DirReverse = 3'd4;

   // Row and column deltas, indexed by direction: N, NE, E, SE, S, SW, W, NW.
   localparam logic signed [1:0] DR [8] = '{-2'sd1, -2'sd1, 2'sd0, 2'sd1,
                                             2'sd1, 2'sd1, 2'sd0, -2'sd1};
   localparam logic signed [1:0] DC [8] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1,
                                             2'sd0, -2'sd1, -2'sd1, -2'sd1};

   localparam logic PlayerB = 1'b0;
   localparam logic PlayerR = 1'b1;

endpackage

// File: rtl/board_step.sv
// One-cell step from (row, col) in direction dir, with off-board detection
// done on signed coordinates so that edges never wrap.
module board_step
   import othello_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = $clog2(N)
) (
   input  logic [CW-1:0] row_i,
   input  logic [CW-1:0] col_i,
   input  dir_t          dir_i,
   output logic [CW-1:0] row_o,
   output logic [CW-1:0] col_o,
   output logic          on_board_o
);

   int r_nxt;
   int c_nxt;

   always_comb begin
      r_nxt      = int'(row_i) + int'(DR[dir_i]);
      c_nxt      = int'(col_i) + int'(DC[dir_i]);
      row_o      = CW'(r_nxt);
      col_o      = CW'(c_nxt);
      on_board_o = (r_nxt >= 0) && (r_nxt < int'(N)) && (c_nxt >= 0) && (c_nxt < int'(N));
   end

endmodule

// File: rtl/flip_engine_seq.sv
// Sequential move resolver: walks the 8 rays from the target one cell per clock,
// flips flanked opponent discs in place and places the new disc if any flipped.
module flip_engine_seq
   import othello_pkg::*;
#(
   parameter int unsigned N   = 8,
   parameter int unsigned CW  = $clog2(N),
   parameter int unsigned FCW = $clog2(N * N)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             player_i,
   input  logic [CW-1:0]    row_i,
   input  logic [CW-1:0]    col_i,
   input  logic [N*N-1:0]   r_in_i,
   input  logic [N*N-1:0]   b_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             valid_move_o,
   output logic [FCW-1:0]   flip_count_o,
   output logic [N*N-1:0]   r_out_o,
   output logic [N*N-1:0]   b_out_o
);

   localparam int unsigned NN = N * N;
   localparam int unsigned RW = CW + 1;

   state_e          state_q, state_d;
   logic [NN-1:0]   r_q, r_d, b_q, b_d;
   logic            player_q, player_d;
   logic [CW-1:0]   trow_q, trow_d, tcol_q, tcol_d;
   logic [CW-1:0]   crow_q, crow_d, ccol_q, ccol_d;
   logic            cok_q, cok_d;
   dir_t            dir_q, dir_d;
   logic [RW-1:0]   run_q, run_d;
   logic [FCW-1:0]  fcnt_q, fcnt_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;

   function automatic logic [FCW-1:0] cell_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
      return FCW'(r) * FCW'(N) + FCW'(c);
   endfunction

   // Cursor stepper: forward while scanning, reversed while walking back to flip.
   dir_t          stp_dir;
   logic [CW-1:0] stp_row, stp_col;
   logic          stp_ok;
   // Ray-start stepper: target plus the delta of the direction about to begin.
   dir_t          beg_dir;
   logic [CW-1:0] beg_row, beg_col;
   logic          beg_ok;

   assign stp_dir = (state_q == StFlip) ? (dir_q ^ DirReverse) : dir_q;
   assign beg_dir = (state_q == StCheck) ? dir_t'(0) : dir_q + dir_t'(1);

   board_step #(.N(N), .CW(CW)) u_step (
      .row_i      (crow_q),
      .col_i      (ccol_q),
      .dir_i      (stp_dir),
      .row_o      (stp_row),
      .col_o      (stp_col),
      .on_board_o (stp_ok)
   );

   board_step #(.N(N), .CW(CW)) u_begin (
      .row_i      (trow_q),
      .col_i      (tcol_q),
      .dir_i      (beg_dir),
      .row_o      (beg_row),
      .col_o      (beg_col),
      .on_board_o (beg_ok)
   );

   logic [FCW-1:0] t_idx, c_idx, s_idx, wr_idx;
   logic [NN-1:0]  opp_q;
   logic           end_dir, wr_en;

   assign t_idx = cell_idx(trow_q, tcol_q);
   assign c_idx = cell_idx(crow_q, ccol_q);
   assign s_idx = cell_idx(stp_row, stp_col);
   assign opp_q = (player_q == PlayerR) ? b_q : r_q;

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      b_d      = b_q;
      player_d = player_q;
      trow_d   = trow_q;
      tcol_d   = tcol_q;
      crow_d   = crow_q;
      ccol_d   = ccol_q;
      cok_d    = cok_q;
      dir_d    = dir_q;
      run_d    = run_q;
      fcnt_d   = fcnt_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      end_dir  = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = s_idx;

      unique case (state_q)
         StIdle: begin
            // The done cycle is itself idle; a start there waits one more cycle.
            if (start_i && !done_q) begin
               r_d      = r_in_i;
               b_d      = b_in_i;
               player_d = player_i;
               trow_d   = row_i;
               tcol_d   = col_i;
               fcnt_d   = '0;
               valid_d  = 1'b0;
               state_d  = StCheck;
            end
         end
         StCheck: begin
            if (r_q[t_idx] || b_q[t_idx]) begin
               state_d = StFin;
            end else begin
               dir_d   = '0;
               crow_d  = beg_row;
               ccol_d  = beg_col;
               cok_d   = beg_ok;
               run_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (!cok_q || !(r_q[c_idx] || b_q[c_idx])) begin
               end_dir = 1'b1;
            end else if (opp_q[c_idx]) begin
               run_d  = run_q + RW'(1);
               crow_d = stp_row;
               ccol_d = stp_col;
               cok_d  = stp_ok;
            end else if (run_q != '0) begin
               state_d = StFlip;
            end else begin
               end_dir = 1'b1;
            end
         end
         StFlip: begin
            crow_d = stp_row;
            ccol_d = stp_col;
            wr_en  = 1'b1;
            wr_idx = s_idx;
            fcnt_d = fcnt_q + FCW'(1);
            run_d  = run_q - RW'(1);
            if (run_q == RW'(1)) begin
               end_dir = 1'b1;
            end
         end
         StFin: begin
            if (fcnt_q != '0) begin
               wr_en   = 1'b1;
               wr_idx  = t_idx;
               valid_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (end_dir) begin
         if (dir_q == DirLast) begin
            state_d = StFin;
         end else begin
            dir_d   = dir_q + dir_t'(1);
            crow_d  = beg_row;
            ccol_d  = beg_col;
            cok_d   = beg_ok;
            run_d   = '0;
            state_d = StScan;
         end
      end

      if (wr_en) begin
         if (player_q == PlayerR) begin
            r_d[wr_idx] = 1'b1;
            b_d[wr_idx] = 1'b0;
         end else begin
            b_d[wr_idx] = 1'b1;
            r_d[wr_idx] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         r_q      <= '0;
         b_q      <= '0;
         player_q <= 1'b0;
         trow_q   <= '0;
         tcol_q   <= '0;
         crow_q   <= '0;
         ccol_q   <= '0;
         cok_q    <= 1'b0;
         dir_q    <= '0;
         run_q    <= '0;
         fcnt_q   <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         b_q      <= b_d;
         player_q <= player_d;
         trow_q   <= trow_d;
         tcol_q   <= tcol_d;
         crow_q   <= crow_d;
         ccol_q   <= ccol_d;
         cok_q    <= cok_d;
         dir_q    <= dir_d;
         run_q    <= run_d;
         fcnt_q   <= fcnt_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
      end
   end

   assign busy_o       = (state_q != StIdle);
   assign done_o       = done_q;
   assign valid_move_o = valid_q;
   assign flip_count_o = fcnt_q;
   assign r_out_o      = r_q;
   assign b_out_o      = b_q;

endmodule

// File: tb/tb_flip_engine_seq.sv
// Bench for flip_engine_seq: hand vectors, corner sequences, and random boards
// checked against a ray-walking reference model.
module tb_flip_engine_seq;

   localparam int N      = 8;
   localparam int Budget = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        player;
   logic [2:0]  row;
   logic [2:0]  col;
   logic [63:0] r_in, b_in;
   logic        busy, done, valid_move;
   logic [5:0]  flip_count;
   logic [63:0] r_out, b_out;

   always #5 clk = ~clk;

   flip_engine_seq #(.N(N)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .player_i     (player),
      .row_i        (row),
      .col_i        (col),
      .r_in_i       (r_in),
      .b_in_i       (b_in),
      .busy_o       (busy),
      .done_o       (done),
      .valid_move_o (valid_move),
      .flip_count_o (flip_count),
      .r_out_o      (r_out),
      .b_out_o      (b_out)
   );

   typedef struct {
      logic [63:0] r;
      logic [63:0] b;
      logic        p;
      int          row;
      int          col;
      logic [63:0] er;
      logic [63:0] eb;
      logic        ev;
      int          efc;
      int          ecyc;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   function automatic logic [5:0] idx6(input int r, input int c);
      return 6'(r * N + c);
   endfunction

   function automatic logic [63:0] bit_at(input int r, input int c);
      logic [63:0] v;
      v = '0;
      v[idx6(r, c)] = 1'b1;
      return v;
   endfunction

   function automatic bit on_brd(input int r, input int c);
      return (r >= 0) && (r < N) && (c >= 0) && (c < N);
   endfunction

   // Reference: walk each ray over the input board; cycles = 3 + per ray (steps + flips + 1).
   function automatic void model(input logic [63:0] r, input logic [63:0] b, input logic p,
                                 input int row0, input int col0,
                                 output logic [63:0] er, output logic [63:0] eb,
                                 output logic ev, output int efc, output int ecyc);
      int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
      int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
      logic [63:0] own, opp;
      own  = p ? r : b;
      opp  = p ? b : r;
      er   = r;
      eb   = b;
      ev   = 1'b0;
      efc  = 0;
      ecyc = 3;
      if (r[idx6(row0, col0)] || b[idx6(row0, col0)]) return;
      for (int d = 0; d < 8; d++) begin
         int k  = 0;
         int rr = row0 + dr[d];
         int cc = col0 + dc[d];
         while (on_brd(rr, cc) && opp[idx6(rr, cc)]) begin
            k++;
            rr += dr[d];
            cc += dc[d];
         end
         if (k > 0 && on_brd(rr, cc) && own[idx6(rr, cc)]) begin
            ecyc += 2 * k + 1;
            for (int j = 1; j <= k; j++) begin
               er[idx6(row0 + j * dr[d], col0 + j * dc[d])] = p;
               eb[idx6(row0 + j * dr[d], col0 + j * dc[d])] = ~p;
               efc++;
            end
         end else begin
            ecyc += k + 1;
         end
      end
      if (efc > 0) begin
         er[idx6(row0, col0)] = p;
         eb[idx6(row0, col0)] = ~p;
         ev = 1'b1;
      end
   endfunction

   function automatic vec_t mk(input logic [63:0] r, input logic [63:0] b, input logic p,
                               input int rw, input int cl, input logic [63:0] er,
                               input logic [63:0] eb, input logic ev, input int efc,
                               input int ecyc);
      vec_t v;
      v.r = r; v.b = b; v.p = p; v.row = rw; v.col = cl;
      v.er = er; v.eb = eb; v.ev = ev; v.efc = efc; v.ecyc = ecyc;
      return v;
   endfunction

   task automatic launch(input vec_t v);
      r_in   = v.r;
      b_in   = v.b;
      player = v.p;
      row    = 3'(v.row);
      col    = 3'(v.col);
      start  = 1'b1;
   endtask

   // cyc = edges after the accept edge until done is visible; poke re-raises start mid-run.
   task automatic wait_done(input bit poke, output int cyc, output bit tmo);
      vec_t junk;
      junk = mk(64'h0, 64'h0, 1'b1, 0, 0, 64'h0, 64'h0, 1'b0, 0, 0);
      cyc  = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (poke) begin
            if (cyc == 3) launch(junk);
            else start = 1'b0;
         end
      end while (!done && cyc < Budget);
      tmo = !done;
   endtask

   // Values updated by edge k belong to cycle k+1 after the start edge.
   task automatic finish_check(input string name, input vec_t v);
      int cyc;
      bit tmo;
      chk({name, ".busy_after_start"}, 64'(busy), 64'(1));
      wait_done(1'b0, cyc, tmo);
      chk({name, ".timeout"}, 64'(tmo), 64'(0));
      chk({name, ".r_out"}, r_out, v.er);
      chk({name, ".b_out"}, b_out, v.eb);
      chk({name, ".valid_move"}, 64'(valid_move), 64'(v.ev));
      chk({name, ".flip_count"}, 64'(flip_count), 64'(v.efc));
      chk({name, ".latency"}, 64'(cyc + 1), 64'(v.ecyc));
      chk({name, ".busy_at_done"}, 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      chk({name, ".done_pulse"}, 64'(done), 64'(0));
   endtask

   task automatic run_vec(input string name, input vec_t v);
      @(negedge clk);
      launch(v);
      @(posedge clk);
      #1;
      start = 1'b0;
      finish_check(name, v);
   endtask

   vec_t        tbl [7];
   vec_t        v, v2;
   logic [63:0] open_r, open_b, row0_r, star_r, star_b;
   int          cyc;
   bit          tmo, seen;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      player = 1'b0;
      row = '0;
      col = '0;
      r_in = '0;
      b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", 64'(busy), 64'(0));
      chk("reset.done", 64'(done), 64'(0));
      chk("reset.valid", 64'(valid_move), 64'(0));
      chk("reset.flip_count", 64'(flip_count), 64'(0));
      chk("reset.r_out", r_out, 64'h0);
      chk("reset.b_out", b_out, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      open_r = bit_at(3, 3) | bit_at(4, 4);
      open_b = bit_at(3, 4) | bit_at(4, 3);
      row0_r = '0;
      for (int c = 1; c <= 6; c++) row0_r |= bit_at(0, c);
      star_r = bit_at(2, 3) | bit_at(3, 4) | bit_at(3, 5) | bit_at(4, 3) | bit_at(5, 3) |
               bit_at(6, 3);
      star_b = bit_at(1, 3) | bit_at(3, 6) | bit_at(7, 3);

      tbl[0] = mk(open_r, open_b, 1'b0, 2, 3, bit_at(4, 4),
                  bit_at(2, 3) | bit_at(3, 3) | bit_at(3, 4) | bit_at(4, 3), 1'b1, 1, 13);
      tbl[1] = mk(open_r, open_b, 1'b0, 0, 0, open_r, open_b, 1'b0, 0, 11);
      tbl[2] = mk(open_r, open_b, 1'b0, 3, 3, open_r, open_b, 1'b0, 0, 3);
      tbl[3] = mk(row0_r, bit_at(0, 0), 1'b0, 0, 7, 64'h0, 64'hFF, 1'b1, 6, 23);
      tbl[4] = mk(bit_at(0, 7) | bit_at(1, 6), bit_at(1, 7), 1'b1, 1, 0,
                  bit_at(0, 7) | bit_at(1, 6), bit_at(1, 7), 1'b0, 0, 11);
      tbl[5] = mk(bit_at(0, 6), bit_at(0, 7), 1'b1, 1, 0,
                  bit_at(0, 6), bit_at(0, 7), 1'b0, 0, 11);
      tbl[6] = mk(star_r, star_b, 1'b0, 3, 3, 64'h0, star_b | star_r | bit_at(3, 3),
                  1'b1, 6, 23);

      for (int i = 0; i < 7; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // start re-raised while busy must not disturb the running move
      @(negedge clk);
      launch(tbl[6]);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b1, cyc, tmo);
      start = 1'b0;
      chk("busy_poke.timeout", 64'(tmo), 64'(0));
      chk("busy_poke.b_out", b_out, tbl[6].eb);
      chk("busy_poke.flip_count", 64'(flip_count), 64'(tbl[6].efc));
      chk("busy_poke.latency", 64'(cyc + 1), 64'(tbl[6].ecyc));
      @(posedge clk);
      #1;

      // start asserted during the done cycle is taken one cycle later
      @(negedge clk);
      launch(tbl[0]);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0, cyc, tmo);
      chk("on_done.first_timeout", 64'(tmo), 64'(0));
      v2 = mk(open_r, open_b, 1'b1, 5, 4, 64'h0, 64'h0, 1'b0, 0, 0);
      model(v2.r, v2.b, v2.p, v2.row, v2.col, v2.er, v2.eb, v2.ev, v2.efc, v2.ecyc);
      launch(v2);
      @(posedge clk);
      #1;
      chk("on_done.ignored", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      start = 1'b0;
      finish_check("on_done.second", v2);

      // asynchronous reset in the middle of a scan
      @(negedge clk);
      launch(tbl[6]);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst.busy_before", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", 64'(busy), 64'(0));
      chk("midrst.done", 64'(done), 64'(0));
      chk("midrst.valid", 64'(valid_move), 64'(0));
      chk("midrst.flip_count", 64'(flip_count), 64'(0));
      chk("midrst.r_out", r_out, 64'h0);
      chk("midrst.b_out", b_out, 64'h0);
      seen = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      chk("midrst.no_done", 64'(seen), 64'(0));
      run_vec("midrst.fresh", tbl[0]);

      // random boards against the reference model
      for (int i = 0; i < 150; i++) begin
         v.r = '0;
         v.b = '0;
         for (int k = 0; k < 64; k++) begin
            int s;
            s = int'($urandom_range(0, 9));
            if (s >= 7) v.r[k] = 1'b1;
            else if (s >= 4) v.b[k] = 1'b1;
         end
         v.p   = 1'($urandom_range(0, 1));
         v.row = int'($urandom_range(0, 7));
         v.col = int'($urandom_range(0, 7));
         model(v.r, v.b, v.p, v.row, v.col, v.er, v.eb, v.ev, v.efc, v.ecyc);
         run_vec($sformatf("rand%0d", i), v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/flip_engine_seq.md
Name: flip_engine_seq

Overview:
- Sequential, parametrised successor to the per-square combinational flip cell.
- Takes a full N x N board (r/b bitplanes), a move position and the side to move.
- Walks all 8 directions one cell per clock, flips every flanked opponent disc and places the new disc only when the move is legal.
- Sits between the move-input controller and the board register file; either colour may move.

Parameters:
- N, 8, board side length (N >= 4).
- CW, $clog2(N), width of row and col coordinates.
- FCW, $clog2(N*N), width of flip_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- player  in  1  0 = b moves (opponent r), 1 = r moves (opponent b).
- row  in  CW  move row, 0 = top.
- col  in  CW  move column, 0 = left.
- r_in  in  N*N  red bitplane; bit index = row*N+col.
- b_in  in  N*N  blue bitplane; same indexing.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is final.
- valid_move  out  1  result legality; held until the next accepted start.
- flip_count  out  FCW  number of discs flipped; held.
- r_out  out  N*N  resulting red plane, registered; held.
- b_out  out  N*N  resulting blue plane, registered; held.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all working registers cleared.
- States:
  - IDLE: on start, latch r_in/b_in into the working planes (r_out/b_out), latch player/row/col, clear flip_count, go to CHECK. start while busy is ignored.
  - CHECK: if the target is occupied (r|b set), go to FIN with legal=0. Otherwise set dir=0 and go to SCAN with cursor = target + delta(dir) and run=0.
  - SCAN, one cursor step per cycle:
    - cursor off-board or empty: end direction.
    - opponent disc: run++, cursor += delta.
    - own disc with run>0: go to FLIP.
    - own disc with run==0: end direction.
  - FLIP, one cell per cycle: cursor -= delta; that cell is set to player colour and its opponent bit cleared; flip_count++ and run--. When run==0, end direction.
  - End direction: if dir==7 go to FIN, else dir++ and go to SCAN from target+delta(dir), run=0.
  - FIN:
    - If flip_count>0: place the player disc at the target and set valid_move=1.
    - Else: planes are bit-identical to the latched inputs and valid_move=0.
    - Pulse done, drop busy, return to IDLE.
- Direction order: 0 N(-1,0), 1 NE(-1,+1), 2 E(0,+1), 3 SE(+1,+1), 4 S(+1,0), 5 SW(+1,-1), 6 W(0,-1), 7 NW(-1,-1).
- Off-board detection: checked before any plane access, with no coordinate wrap-around. Col N-1 stepping E is off-board, not col 0.
- Latency:
  - Occupied target: done exactly 3 cycles after the start edge.
  - Otherwise: 3 + sum over dirs (scan steps + flips + 1) cycles; never more than 8*(2N-1)+3.
- Intermediate values: r_out/b_out show intermediate flips while busy. Consumers sample them only on done.
- Asynchronous reset mid-operation: abort to IDLE, all outputs 0, no done pulse.
- start high in the same cycle as done: ignored; it is accepted on the next IDLE cycle.

Decomposition:
- Package othello_pkg holds:
  - the state enum;
  - the direction index type;
  - DR/DC signed delta constants per direction;
  - player encoding constants.
- One combinational sub-module, board_step: inputs row, col, dir; outputs next row, next col, on_board. Instantiated once for forward stepping; backward stepping uses the opposite direction (dir^4).

Test Plan:
- Standard opening (r at (3,3),(4,4); b at (3,4),(4,3)), player=0, move (2,3) -> done with valid_move=1, flip_count=1; r_out=only (4,4); b_out = (2,3),(3,3),(3,4),(4,3).
- Same opening, player=0, move (0,0) -> valid_move=0, flip_count=0, r_out==r_in, b_out==b_in.
- Occupied target (3,3) -> done exactly 3 cycles after start, valid_move=0, planes unchanged.
- Row 0 b at (0,0), r at (0,1..6), player=0, move (0,7) -> flip_count=6, whole row 0 blue. Plus an edge case: r at (0,7) with player=1 moving (1,0) must not wrap to flip anything.
- Multi-direction star: target flanked in 3 directions with 1, 2 and 3 opponent discs -> flip_count=6, all flipped, plus the target set.
- start pulsed again while busy -> ignored; rst_n low mid-SCAN -> all outputs 0 next cycle, no done pulse, and a fresh start afterwards works.
